// File: rtl/vertex_pkg.sv
// Shared definitions for the vertex stream RAM: burst FSM states and the
// default geometry of the vertex store.
package vertex_pkg;

  localparam int VERTEX_DATA_W = 10;
  localparam int VERTEX_ADDR_W = 6;

  // Burst engine states. The encoding is exported on dbg_state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vertex_state_e;

endpackage

// File: rtl/vertex_skid_fifo.sv
// Two-entry FIFO between the RAM read and the output stream. It holds
// {data, addr, last} words and reports its occupancy so the read issuer
// never overruns it while the consumer stalls.
module vertex_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   occupancy
);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic         wr_sel;
  logic         rd_sel;
  logic [1:0]   occ;

  // Storage, pointers and occupancy; push only when occ<2, pop only when occ>0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_sel) entry1 <= din;
        else        entry0 <= din;
        wr_sel <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign dout      = rd_sel ? entry1 : entry0;
  assign occupancy = occ;

endmodule

// File: rtl/vertex_stream_ram.sv
// Vertex store with one write port and a burst read engine that streams
// `count` consecutive entries from `base_addr` (wrapping modulo DEPTH) on
// a valid/ready interface.
//
// Configuration macro: VERTEX_RAM_FWD_EN
//   defined   : write-first bypass; a write to the address being read in
//               the same cycle delivers the new data on that beat.
//   undefined : read-first; the colliding read returns the old data.
//
// Handshake: a beat transfers on a cycle where out_valid && out_ready are
// both high; while out_valid=1 and out_ready=0 the beat (data, addr, last)
// is held unchanged, and out_valid never drops before acceptance.
module vertex_stream_ram
  import vertex_pkg::*;
#(
  parameter int DATA_W = VERTEX_DATA_W,
  parameter int ADDR_W = VERTEX_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int SKID_W = DATA_W + ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  vertex_state_e     state;
  vertex_state_e     state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   beat_cnt;

  logic              rd_en;
  logic              beat_fire;
  logic [DATA_W-1:0] rd_word;
  logic [SKID_W-1:0] skid_din;
  logic [SKID_W-1:0] skid_dout;
  logic [1:0]        skid_occ;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;
  logic              head_last;

  // The RAM read register is the skid entry itself: a read issued in one
  // cycle lands in the skid at the closing edge, so reads in flight are
  // already counted by the skid occupancy and the gate is occupancy < 2.
  assign rd_en     = (state == FETCH) && (issue_cnt != '0) && (skid_occ < 2'd2);
  assign out_valid = (skid_occ != 2'd0);
  assign beat_fire = out_valid && out_ready;

`ifdef VERTEX_RAM_FWD_EN
  // Write-first: a same-cycle write to the read address bypasses the array.
  always_comb begin
    rd_word = mem[rd_ptr];
    if (wren && (wraddress == rd_ptr)) rd_word = data;
  end
`else
  // Read-first: the array still holds the old word during the write cycle.
  always_comb begin
    rd_word = mem[rd_ptr];
  end
`endif

  assign skid_din = {rd_word, rd_ptr, (issue_cnt == (ADDR_W+1)'(1))};

  vertex_skid_fifo #(
    .W (SKID_W)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_en),
    .din       (skid_din),
    .pop       (beat_fire),
    .dout      (skid_dout),
    .occupancy (skid_occ)
  );

  assign {head_data, head_addr, head_last} = skid_dout;
  assign out_data  = out_valid ? head_data : '0;
  assign out_addr  = out_valid ? head_addr : '0;
  assign out_last  = out_valid & head_last;
  assign dbg_state = state;

  // Vertex array write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wren) mem[wraddress] <= data;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Read pointer, issue counter and beat counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if ((state == IDLE) && start && (count != '0)) begin
        rd_ptr    <= base_addr;
        issue_cnt <= count;
        beat_cnt  <= count;
      end else begin
        if (rd_en) begin
          rd_ptr    <= rd_ptr + ADDR_W'(1);
          issue_cnt <= issue_cnt - (ADDR_W+1)'(1);
        end
        if (beat_fire) beat_cnt <= beat_cnt - (ADDR_W+1)'(1);
      end
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count == '0) ? DONE : FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (rd_en && (issue_cnt == (ADDR_W+1)'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave as the last beat handshakes so done follows it directly.
        if ((beat_cnt == '0) || ((beat_cnt == (ADDR_W+1)'(1)) && beat_fire))
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
